// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: bundle layouts, FSM states, access sizes
// and LoongArch load/store opcodes (opcodes only with MEM_SUBWORD_EN).
package mem_stage_pkg;

  localparam int MEM_IN_W  = 138;
  localparam int MEM_OUT_W = 103;

`ifdef MEM_SUBWORD_EN
  localparam logic [9:0] OP_LD_B  = 10'b0010100000;
  localparam logic [9:0] OP_LD_H  = 10'b0010100001;
  localparam logic [9:0] OP_LD_W  = 10'b0010100010;
  localparam logic [9:0] OP_ST_B  = 10'b0010100100;
  localparam logic [9:0] OP_ST_H  = 10'b0010100101;
  localparam logic [9:0] OP_ST_W  = 10'b0010100110;
  localparam logic [9:0] OP_LD_BU = 10'b0010101000;
  localparam logic [9:0] OP_LD_HU = 10'b0010101001;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        inst_ld_w;
    logic        mem_we;
    logic        res_from_mem;
    logic        gr_we;
    logic [31:0] rkd;
    logic [4:0]  rf_waddr;
    logic [31:0] result;
  } ex_mem_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        gr_we;
    logic [4:0]  rf_waddr;
    logic [31:0] final_result;
  } mem_wb_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-SRAM bus between the MEM stage (master) and the data memory (slave).
// en/we/addr/wdata issue an access; rdata returns one cycle after a read.
interface mem_stage_if;

  logic        en;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output en,
    output we,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  en,
    input  we,
    input  addr,
    input  wdata,
    output rdata
  );

endinterface

// File: rtl/mem_load_align.sv
// Load lane select and extension: rdata, off, size, sign -> data.
// Pass-through unless MEM_SUBWORD_EN is defined.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  size_e       size,
  input  logic        sign,
  output logic [31:0] data
);

`ifdef MEM_SUBWORD_EN
  logic [7:0]  b8;
  logic [15:0] h16;

  always_comb begin
    b8 = rdata[7:0];
    unique case (off)
      2'd0: b8 = rdata[7:0];
      2'd1: b8 = rdata[15:8];
      2'd2: b8 = rdata[23:16];
      2'd3: b8 = rdata[31:24];
      default: ;
    endcase
  end

  assign h16 = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    unique case (size)
      SZ_B: data = {{24{sign & b8[7]}}, b8};
      SZ_H: data = {{16{sign & h16[15]}}, h16};
      default: ;
    endcase
  end
`else
  logic unused_sel;

  assign unused_sel = ^{off, size, sign};
  assign data = rdata;
`endif

endmodule

// File: rtl/mem_stage.sv
// MEM stage: issues the data-SRAM access, waits out the read latency,
// forwards to ID and registers MEM->WB. Optional macro: MEM_SUBWORD_EN.
// Ports: clk, rst (sync, active-high), EX_to_MEM_reg, WB_allowin,
// MEM_allowin, data_sram (bus), front_valid/stall/addr/data, MEM_to_WB_reg.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MEM_IN_W-1:0]  EX_to_MEM_reg,
  input  logic                 WB_allowin,
  output logic                 MEM_allowin,
  mem_stage_if.master          data_sram,
  output logic                 front_valid,
  output logic                 front_stall,
  output logic [4:0]           front_addr,
  output logic [31:0]          front_data,
  output logic [MEM_OUT_W-1:0] MEM_to_WB_reg
);

  ex_mem_t     b;
  mem_wb_t     wb;
  state_e      state;
  size_e       size;
  logic        sign;
  logic        is_ld;
  logic        is_st;
  logic        readygo;
  logic        en;
  logic [3:0]  st_we;
  logic [31:0] st_wdata;
  logic [31:0] hold_rdata;
  logic [31:0] raw;
  logic [31:0] load_data;
  logic [31:0] final_result;
  logic        unused_bits;

  assign b = ex_mem_t'(EX_to_MEM_reg);
  assign unused_bits = b.inst_ld_w;

`ifdef MEM_SUBWORD_EN
  logic [9:0] op;

  assign op = b.ir[31:22];

  always_comb begin
    size = SZ_W;
    sign = 1'b0;
    unique case (1'b1)
      op == OP_LD_B:  begin size = SZ_B; sign = 1'b1; end
      op == OP_LD_H:  begin size = SZ_H; sign = 1'b1; end
      op == OP_LD_BU: size = SZ_B;
      op == OP_LD_HU: size = SZ_H;
      op == OP_ST_B:  size = SZ_B;
      op == OP_ST_H:  size = SZ_H;
      default: ;
    endcase
  end

  always_comb begin
    st_we    = 4'hf;
    st_wdata = b.rkd;
    unique case (size)
      SZ_B: begin
        st_we    = 4'b0001 << b.result[1:0];
        st_wdata = {4{b.rkd[7:0]}};
      end
      SZ_H: begin
        st_we    = b.result[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{b.rkd[15:0]}};
      end
      default: ;
    endcase
  end
`else
  assign size     = SZ_W;
  assign sign     = 1'b0;
  assign st_we    = 4'hf;
  assign st_wdata = b.rkd;
`endif

  assign is_ld = b.valid & b.res_from_mem;
  assign is_st = b.valid & b.mem_we;

  // only a fresh load in IDLE is not ready; bubbles count as ready
  assign readygo     = (state != S_IDLE) | ~is_ld;
  assign MEM_allowin = ~b.valid | readygo & WB_allowin;

  // strobe only in IDLE so a held access is never re-issued
  assign en = ~rst & (state == S_IDLE) & (is_ld | is_st);

  assign data_sram.en    = en;
  assign data_sram.we    = (en & is_st) ? st_we : 4'h0;
  assign data_sram.addr  = b.result;
  assign data_sram.wdata = st_wdata;

  assign raw = (state == S_DONE) ? hold_rdata : data_sram.rdata;

  mem_load_align u_align (
    .rdata (raw),
    .off   (b.result[1:0]),
    .size  (size),
    .sign  (sign),
    .data  (load_data)
  );

  assign final_result = b.res_from_mem ? load_data : b.result;

  assign front_valid = b.valid & b.gr_we & readygo;
  assign front_stall = b.valid & b.gr_we & b.res_from_mem & ~readygo;
  assign front_addr  = b.rf_waddr;
  assign front_data  = final_result;

  assign wb = '{
    valid:        b.valid,
    pc:           b.pc,
    ir:           b.ir,
    gr_we:        b.gr_we,
    rf_waddr:     b.rf_waddr,
    final_result: final_result
  };

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      hold_rdata    <= 32'h0;
      MEM_to_WB_reg <= '0;
    end else begin
      if (readygo & WB_allowin) begin
        MEM_to_WB_reg <= wb;
      end
      if (MEM_allowin) begin
        state <= S_IDLE;
      end else begin
        unique case (state)
          S_IDLE: state <= is_ld ? S_WAIT : S_DONE;
          S_WAIT: begin
            hold_rdata <= data_sram.rdata;
            state      <= S_DONE;
          end
          default: state <= S_DONE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus random
// ALU/ld.w/st.w traffic against a word-level memory and latency model.
module tb_mem_stage;

  localparam logic [9:0] T_ALU  = 10'b0000000000;
  localparam logic [9:0] T_LD_W = 10'b0010100010;
  localparam logic [9:0] T_ST_W = 10'b0010100110;
  localparam logic [9:0] T_LD_B = 10'b0010100000;
  localparam logic [9:0] T_LD_H = 10'b0010100001;
  localparam logic [9:0] T_ST_B = 10'b0010100100;
  localparam logic [9:0] T_LDBU = 10'b0010101000;

  logic         clk = 1'b0;
  logic         rst;
  logic [137:0] ex;
  logic         wb_allowin;
  logic         mem_allowin;
  logic         front_valid;
  logic         front_stall;
  logic [4:0]   front_addr;
  logic [31:0]  front_data;
  logic [102:0] wb_reg;
  logic         scramble = 1'b0;
  logic [31:0]  sram_mem [0:4095];
  logic [31:0]  ref_mem [int];
  logic [31:0]  wtmp;
  int           checks = 0;
  int           passed = 0;

  mem_stage_if sram();

  always #5 clk = ~clk;

  mem_stage dut (
    .clk            (clk),
    .rst            (rst),
    .EX_to_MEM_reg  (ex),
    .WB_allowin     (wb_allowin),
    .MEM_allowin    (mem_allowin),
    .data_sram      (sram),
    .front_valid    (front_valid),
    .front_stall    (front_stall),
    .front_addr     (front_addr),
    .front_data     (front_data),
    .MEM_to_WB_reg  (wb_reg)
  );

  // data SRAM: byte-enable writes, 1-cycle synchronous read
  always @(posedge clk) begin
    if (sram.en) begin
      wtmp = sram_mem[sram.addr[13:2]];
      for (int i = 0; i < 4; i++)
        if (sram.we[i]) wtmp[8*i +: 8] = sram.wdata[8*i +: 8];
      sram_mem[sram.addr[13:2]] <= wtmp;
      if (sram.we == 4'h0) sram.rdata <= sram_mem[sram.addr[13:2]];
    end else if (scramble) begin
      sram.rdata <= 32'h0;
    end
  end

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    int k = int'(a[13:2]);
    return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
  endfunction

  // kind: 0 ALU, 1 store, 2 load
  function automatic logic [137:0] mk(input int kind, input logic [9:0] op,
      input logic [31:0] pc, input logic [31:0] addr,
      input logic [31:0] rkd, input logic [4:0] wa);
    logic ldw = (kind == 2) && (op == T_LD_W);
    return {1'b1, pc, op, 22'h15a5a, ldw, kind == 1, kind == 2,
            kind != 1, rkd, wa, addr};
  endfunction

  function automatic logic [102:0] exp_wb(input int kind, input logic [9:0] op,
      input logic [31:0] pc, input logic [4:0] wa, input logic [31:0] fin);
    return {1'b1, pc, op, 22'h15a5a, kind != 1, wa, fin};
  endfunction

  // one instruction through MEM; WB refuses for the first `stalls` cycles
  task automatic run(input logic [137:0] bnd, input int stalls,
      output int ens, output int lat, output logic [102:0] wbv,
      output logic [3:0] swe, output logic [31:0] swd);
    int k = 0;
    bit done = 0;
    ens = 0; swe = 4'h0; swd = 32'h0;
    ex = bnd;
    while (!done && k < 40) begin
      wb_allowin = (k >= stalls);
      @(negedge clk);
      if (sram.en) begin
        if (ens == 0) begin swe = sram.we; swd = sram.wdata; end
        ens++;
      end
      if (mem_allowin) done = 1;
      @(posedge clk); #1;
      k++;
    end
    lat = k;
    ex = '0;
    wb_allowin = 1'b1;
    wbv = wb_reg;
    if (!done) begin
      checks++;
      $display("FAIL run_timeout: accepted=0 required=1");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ex = '0; wb_allowin = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (wb_reg !== 103'h0) $display("FAIL reset_wb: got %h want 0", wb_reg);
    else passed++;
    checks++;
    if (sram.en !== 1'b0 || sram.we !== 4'h0)
      $display("FAIL reset_en: got en=%b we=%h want 0/0", sram.en, sram.we);
    else passed++;
    checks++;
    if (mem_allowin !== 1'b1) $display("FAIL reset_allowin: got %b want 1", mem_allowin);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_store_load();
    logic [137:0] st = mk(1, T_ST_W, 32'h100, 32'h1004, 32'hDEADBEEF, 5'd0);
    logic [137:0] ld = mk(2, T_LD_W, 32'h104, 32'h1004, 32'h0, 5'd7);
    ex = st; wb_allowin = 1'b1;
    @(negedge clk);
    checks++;
    if (sram.en !== 1'b1 || sram.we !== 4'hf || sram.wdata !== 32'hDEADBEEF)
      $display("FAIL st_issue: got en=%b we=%h wd=%h want 1/f/deadbeef",
               sram.en, sram.we, sram.wdata);
    else passed++;
    ref_mem[int'(32'h1004 >> 2)] = 32'hDEADBEEF;
    @(posedge clk); #1;
    checks++;
    if (wb_reg !== exp_wb(1, T_ST_W, 32'h100, 5'd0, 32'h1004))
      $display("FAIL st_wb: got %h want %h", wb_reg,
               exp_wb(1, T_ST_W, 32'h100, 5'd0, 32'h1004));
    else passed++;
    ex = ld;
    @(negedge clk);
    checks++;
    if (sram.en !== 1'b1 || front_stall !== 1'b1 || mem_allowin !== 1'b0)
      $display("FAIL ld_cycle0: got en=%b stall=%b allowin=%b want 1/1/0",
               sram.en, front_stall, mem_allowin);
    else passed++;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (front_valid !== 1'b1 || front_data !== ref_rd(32'h1004) ||
        front_addr !== 5'd7 || sram.en !== 1'b0)
      $display("FAIL ld_cycle1: got fv=%b fd=%h fa=%0d en=%b want 1/%h/7/0",
               front_valid, front_data, front_addr, sram.en, ref_rd(32'h1004));
    else passed++;
    @(posedge clk); #1;
    ex = '0;
    checks++;
    if (wb_reg !== exp_wb(2, T_LD_W, 32'h104, 5'd7, ref_rd(32'h1004)))
      $display("FAIL ld_wb: got %h want %h", wb_reg,
               exp_wb(2, T_LD_W, 32'h104, 5'd7, ref_rd(32'h1004)));
    else passed++;
  endtask

  task automatic test_held_load();
    int ens, lat;
    logic [102:0] w;
    logic [3:0] we;
    logic [31:0] wd;
    scramble = 1'b1;
    run(mk(2, T_LD_W, 32'h200, 32'h1004, 32'h0, 5'd3), 3, ens, lat, w, we, wd);
    scramble = 1'b0;
    checks++;
    if (w !== exp_wb(2, T_LD_W, 32'h200, 5'd3, ref_rd(32'h1004)))
      $display("FAIL held_ld_wb: got %h want %h", w,
               exp_wb(2, T_LD_W, 32'h200, 5'd3, ref_rd(32'h1004)));
    else passed++;
    checks++;
    if (ens != 1 || lat != 4)
      $display("FAIL held_ld_en: got en=%0d lat=%0d want 1/4", ens, lat);
    else passed++;
  endtask

  task automatic test_held_store();
    int ens, lat;
    logic [102:0] w;
    logic [3:0] we;
    logic [31:0] wd;
    run(mk(1, T_ST_W, 32'h300, 32'h1008, 32'h13572468, 5'd0), 4, ens, lat, w, we, wd);
    ref_mem[int'(32'h1008 >> 2)] = 32'h13572468;
    checks++;
    if (ens != 1 || lat != 5)
      $display("FAIL held_st_en: got en=%0d lat=%0d want 1/5", ens, lat);
    else passed++;
    checks++;
    if (sram_mem[12'h402] !== 32'h13572468)
      $display("FAIL held_st_mem: got %h want 13572468", sram_mem[12'h402]);
    else passed++;
  endtask

  task automatic test_reset_in_wait();
    logic [102:0] sw = exp_wb(0, T_ALU, 32'h400, 5'd9, 32'h55);
    ex = mk(0, T_ALU, 32'h400, 32'h55, 32'h0, 5'd9); wb_allowin = 1'b1;
    @(posedge clk); #1;
    ex = mk(2, T_LD_W, 32'h404, 32'h1004, 32'h0, 5'd4);
    checks++;
    if (wb_reg !== sw) $display("FAIL rw_pre: got %h want %h", wb_reg, sw);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; ex = '0;
    checks++;
    if (wb_reg !== 103'h0) $display("FAIL rw_clear: got %h want 0", wb_reg);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (wb_reg[102] !== 1'b0) $display("FAIL rw_drop: got valid=%b want 0", wb_reg[102]);
    else passed++;
  endtask

  task automatic test_random();
    int ens, lat, kind, st, lat_exp, base;
    logic [102:0] w, e;
    logic [3:0] we;
    logic [31:0] wd, a, d, fin;
    logic [9:0] op;
    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 2);
      st = $urandom_range(0, 3);
      a = 32'h3000 + 4 * $urandom_range(0, 7);
      d = $urandom;
      op = (kind == 0) ? T_ALU : (kind == 1) ? T_ST_W : T_LD_W;
      if (kind == 0) a = $urandom;
      fin = (kind == 2) ? ref_rd(a) : a;
      run(mk(kind, op, 32'h1000 + n * 4, a, d, 5'(n)), st, ens, lat, w, we, wd);
      if (kind == 1) ref_mem[int'(a[13:2])] = d;
      e = exp_wb(kind, op, 32'h1000 + n * 4, 5'(n), fin);
      base = (kind == 2) ? 1 : 0;
      lat_exp = ((st > base) ? st : base) + 1;
      checks++;
      if (w !== e) $display("FAIL rand_wb[%0d]: got %h want %h", n, w, e);
      else passed++;
      checks++;
      if (lat != lat_exp || ens != ((kind == 0) ? 0 : 1))
        $display("FAIL rand_timing[%0d]: got lat=%0d en=%0d want %0d/%0d",
                 n, lat, ens, lat_exp, (kind == 0) ? 0 : 1);
      else passed++;
      if (kind == 1) begin
        checks++;
        if (we !== 4'hf || wd !== d)
          $display("FAIL rand_st[%0d]: got we=%h wd=%h want f/%h", n, we, wd, d);
        else passed++;
      end
    end
  endtask

`ifdef MEM_SUBWORD_EN
  task automatic sub_ld(input logic [9:0] op, input logic [31:0] a,
      input logic [31:0] want, input string nm);
    int ens, lat;
    logic [102:0] w;
    logic [3:0] we;
    logic [31:0] wd;
    run(mk(2, op, 32'h500, a, 32'h0, 5'd1), 0, ens, lat, w, we, wd);
    checks++;
    if (w[31:0] !== want) $display("FAIL %s: got %h want %h", nm, w[31:0], want);
    else passed++;
  endtask

  task automatic test_subword();
    int ens, lat;
    logic [102:0] w;
    logic [3:0] we;
    logic [31:0] wd;
    run(mk(1, T_ST_W, 32'h600, 32'h2000, 32'h80FF7F01, 5'd0), 0, ens, lat, w, we, wd);
    sub_ld(T_LD_B, 32'h2003, 32'hFFFFFF80, "ld_b");
    sub_ld(T_LDBU, 32'h2002, 32'h000000FF, "ld_bu");
    sub_ld(T_LD_H, 32'h2000, 32'h00007F01, "ld_h");
    run(mk(1, T_ST_B, 32'h604, 32'h2001, 32'h123456AB, 5'd0), 0, ens, lat, w, we, wd);
    checks++;
    if (we !== 4'b0010 || wd !== 32'hABABABAB)
      $display("FAIL st_b: got we=%b wd=%h want 0010/abababab", we, wd);
    else passed++;
    sub_ld(T_LD_W, 32'h2000, 32'h80FFAB01, "st_b_merge");
  endtask
`endif

  initial begin
    for (int i = 0; i < 4096; i++) sram_mem[i] = 32'h0;
    sram.rdata = 32'h0;
    test_reset();
    test_store_load();
    test_held_load();
    test_held_store();
    test_reset_in_wait();
    test_random();
`ifdef MEM_SUBWORD_EN
    test_subword();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
